// File: rtl/pc_pkg.sv
// Shared types and default parameter values for the program-counter unit.
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BRANCH,
        SEL_JUMP,
        SEL_JR,
        SEL_RET,
        SEL_EXC
    } next_pc_sel_t;

    localparam int          DEF_ADDR_W     = 32;
    localparam int          DEF_INC        = 1;
    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0100;
    localparam int          DEF_RAS_DEPTH  = 4;

endpackage

// File: rtl/pc_unit_return_addr_stack.sv
// Circular return-address stack: a push while full overwrites the oldest entry.
// Popping an empty stack is ignored.
module return_addr_stack
    import pc_pkg::*;
#(
    parameter int DEPTH = DEF_RAS_DEPTH,
    parameter int W     = DEF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           push_data,
    output logic [W-1:0]           top,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] top_ptr;
    logic             swap;

    // ptr addresses the next free slot, so the top entry sits just below it.
    assign top_ptr = ptr - PTR_W'(1);
    assign top     = mem[top_ptr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign swap    = push && pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (swap) begin
            ptr   <= ptr;
            count <= count;
        end else if (push) begin
            ptr <= ptr + PTR_W'(1);
            if (!full)
                count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            ptr   <= top_ptr;
            count <= count - CNT_W'(1);
        end
    end

    // A swap replaces the top in place; a plain push lands on the free slot.
    always_ff @(posedge clk) begin
        if (!reset && push)
            mem[swap ? top_ptr : ptr] <= push_data;
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: prioritised next-PC mux, PC register, return-address
// stack for call/return and a one-cycle return-underflow flag.
module pc_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                INC        = DEF_INC,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEF_RESET_PC),
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEF_EXC_VECTOR),
    parameter int                RAS_DEPTH  = DEF_RAS_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         branch,
    input  logic                         zero,
    input  logic [ADDR_W-1:0]            branch_offset,
    input  logic                         jump,
    input  logic [ADDR_W-1:0]            jump_target,
    input  logic                         jr,
    input  logic [ADDR_W-1:0]            jr_target,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         exc,
    output logic [ADDR_W-1:0]            pc,
    output logic [ADDR_W-1:0]            pc_plus_inc,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_full,
    output logic                         ret_underflow
);

    localparam logic [ADDR_W-1:0] INC_V = ADDR_W'(INC);

    next_pc_sel_t      sel;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty;
    logic              advance;
    logic              push;
    logic              pop;

    assign pc_plus_inc = pc + INC_V;

    // Exceptions and stalls freeze the return stack; call/ret are dropped.
    assign advance = !exc && !stall;
    assign push    = call && advance;
    assign pop     = ret && advance;

    always_comb begin
        sel = SEL_SEQ;
        if (exc)
            sel = SEL_EXC;
        else if (ret)
            sel = SEL_RET;
        else if (jr)
            sel = SEL_JR;
        else if (jump)
            sel = SEL_JUMP;
        else if (branch && zero)
            sel = SEL_BRANCH;
    end

    // An empty-stack return falls through to the sequential address.
    always_comb begin
        next_pc = pc_plus_inc;
        case (sel)
            SEL_EXC:    next_pc = EXC_VECTOR;
            SEL_RET:    next_pc = ras_empty ? pc_plus_inc : ras_top;
            SEL_JR:     next_pc = jr_target;
            SEL_JUMP:   next_pc = jump_target;
            SEL_BRANCH: next_pc = pc_plus_inc + branch_offset;
            default:    next_pc = pc_plus_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= RESET_PC;
            ret_underflow <= 1'b0;
        end else begin
            ret_underflow <= pop && ras_empty;
            if (exc || !stall)
                pc <= next_pc;
        end
    end

    return_addr_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus_inc),
        .top       (ras_top),
        .count     (ras_count),
        .full      (ras_full),
        .empty     (ras_empty)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Directed plus randomized bench for pc_unit (default parameters) against a
// queue-based model of the PC and return-address stack.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset, stall, branch, zero, jump, jr, call, ret, exc;
    logic [31:0] branch_offset, jump_target, jr_target;
    logic [31:0] pc, pc_plus_inc;
    logic [2:0]  ras_count;
    logic        ras_full, ret_underflow;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_uf;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch        (branch),
        .zero          (zero),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .jr            (jr),
        .jr_target     (jr_target),
        .call          (call),
        .ret           (ret),
        .exc           (exc),
        .pc            (pc),
        .pc_plus_inc   (pc_plus_inc),
        .ras_count     (ras_count),
        .ras_full      (ras_full),
        .ret_underflow (ret_underflow)
    );

    task automatic clear_inputs();
        reset = 0; stall = 0; branch = 0; zero = 0; jump = 0; jr = 0;
        call = 0; ret = 0; exc = 0;
        branch_offset = '0; jump_target = '0; jr_target = '0;
    endtask

    // Reference behaviour: priority chain, with a 4-deep stack that drops its oldest entry.
    task automatic model_update();
        logic [31:0] seq;
        seq = m_pc + 32'd1;
        if (reset) begin
            m_pc = 32'h0; m_ras.delete(); m_uf = 0;
        end else if (exc) begin
            m_pc = 32'h100; m_uf = 0;
        end else if (stall) begin
            m_uf = 0;
        end else begin
            m_uf = 0;
            if (ret) begin
                if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                else begin m_pc = seq; m_uf = 1; end
            end else if (jr) m_pc = jr_target;
            else if (jump) m_pc = jump_target;
            else if (branch && zero) m_pc = seq + branch_offset;
            else m_pc = seq;
            if (call) begin
                m_ras.push_back(seq);
                if (m_ras.size() > 4) void'(m_ras.pop_front());
            end
        end
    endtask

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        check_value("pc", pc, m_pc);
        check_value("pc_plus_inc", pc_plus_inc, m_pc + 32'd1);
        check_value("ras_count", 32'(ras_count), 32'(m_ras.size()));
        check_value("ras_full", 32'(ras_full), 32'(m_ras.size() == 4));
        check_value("ret_underflow", 32'(ret_underflow), 32'(m_uf));
    endtask

    task automatic apply_stimulus();
        model_update();
        @(posedge clk);
        #1;
        check_output();
    endtask

    initial begin
        clear_inputs();
        m_pc = '0; m_uf = 0;
        #2;

        // Reset, then free-running sequential fetch
        reset = 1; apply_stimulus();
        check_value("reset_pc", pc, 32'h0);
        check_value("reset_count", 32'(ras_count), 32'h0);
        clear_inputs();
        for (int i = 1; i <= 3; i++) begin
            apply_stimulus();
            check_value("seq_pc", pc, 32'(i));
        end

        // Branch taken and not taken from pc=10
        clear_inputs(); jump = 1; jump_target = 32'd10; apply_stimulus();
        clear_inputs(); branch = 1; zero = 1; branch_offset = -32'sd3; apply_stimulus();
        check_value("branch_taken", pc, 32'd8);
        clear_inputs(); jump = 1; jump_target = 32'd10; apply_stimulus();
        clear_inputs(); branch = 1; zero = 0; branch_offset = -32'sd3; apply_stimulus();
        check_value("branch_not_taken", pc, 32'd11);

        // Jump-and-link from pc=5, return, then underflow for exactly one cycle
        clear_inputs(); jump = 1; jump_target = 32'd5; apply_stimulus();
        clear_inputs(); call = 1; jump = 1; jump_target = 32'd40; apply_stimulus();
        check_value("jal_pc", pc, 32'd40);
        check_value("jal_count", 32'(ras_count), 32'd1);
        clear_inputs(); ret = 1; apply_stimulus();
        check_value("ret_pc", pc, 32'd6);
        clear_inputs(); ret = 1; apply_stimulus();
        check_value("underflow_pc", pc, 32'd7);
        check_value("underflow_pulse", 32'(ret_underflow), 32'd1);
        clear_inputs(); apply_stimulus();
        check_value("underflow_cleared", 32'(ret_underflow), 32'd0);

        // Overfill the stack: five calls, then unwind
        clear_inputs(); reset = 1; apply_stimulus();
        for (int i = 0; i < 5; i++) begin
            clear_inputs(); call = 1; jump = 1; jump_target = 32'(i + 1); apply_stimulus();
        end
        check_value("overfill_full", 32'(ras_full), 32'd1);
        check_value("overfill_count", 32'(ras_count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            clear_inputs(); ret = 1; apply_stimulus();
            check_value("unwind_pc", pc, 32'(5 - i));
        end
        clear_inputs(); ret = 1; apply_stimulus();
        check_value("fifth_ret_underflow", 32'(ret_underflow), 32'd1);

        // Stall holds through a jump; exception overrides stall and ignores call
        clear_inputs(); call = 1; apply_stimulus();
        clear_inputs(); stall = 1; jump = 1; jump_target = 32'd77; apply_stimulus();
        apply_stimulus();
        check_value("stall_hold", pc, 32'd4);
        clear_inputs(); stall = 1; exc = 1; call = 1; apply_stimulus();
        check_value("exc_pc", pc, 32'h100);
        check_value("exc_count", 32'(ras_count), 32'd1);

        // Wrap-around, then reset during a call
        clear_inputs(); jump = 1; jump_target = 32'hFFFF_FFFF; apply_stimulus();
        clear_inputs(); apply_stimulus();
        check_value("wrap_pc", pc, 32'h0);
        clear_inputs(); call = 1; apply_stimulus();
        check_value("pre_reset_count", 32'(ras_count), 32'd2);
        clear_inputs(); reset = 1; call = 1; apply_stimulus();
        check_value("reset_call_pc", pc, 32'h0);
        check_value("reset_call_count", 32'(ras_count), 32'd0);

        // Randomized mixture of all controls
        for (int n = 0; n < 600; n++) begin
            clear_inputs();
            reset         = ($urandom_range(0, 99) < 2);
            exc           = ($urandom_range(0, 99) < 4);
            stall         = ($urandom_range(0, 99) < 10);
            ret           = ($urandom_range(0, 99) < 25);
            call          = ($urandom_range(0, 99) < 30);
            jr            = ($urandom_range(0, 99) < 10);
            jump          = ($urandom_range(0, 99) < 15);
            branch        = ($urandom_range(0, 99) < 30);
            zero          = $urandom_range(0, 1) == 1;
            branch_offset = 32'($urandom_range(0, 63)) - 32'd32;
            jump_target   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            jr_target     = $urandom;
            apply_stimulus();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit; successor to the single-cycle PC.
- Generalises address width, increment and reset vector.
- Adds stall, absolute jump, jump-register, exception vectoring and a circular return-address stack (RAS) for call/return.
- Sits at the front of the datapath and drives the instruction-memory address each cycle.

Parameters:
ADDR_W, 32, width of PC and all address/offset inputs
INC, 1, sequential increment (1 = word-addressed IM, 4 = byte-addressed)
RESET_PC, 0, PC value loaded on reset
EXC_VECTOR, 32'h0000_0100, PC loaded on exception
RAS_DEPTH, 4, return-address stack entries (power of 2, >=2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  reset, synchronous, active-high
stall  input  1  hold PC and RAS this cycle
branch  input  1  conditional branch instruction
zero  input  1  ALU zero flag; branch taken when branch&&zero
branch_offset  input  ADDR_W  sign-extended branch offset, in INC units already scaled
jump  input  1  absolute jump
jump_target  input  ADDR_W  absolute jump address
jr  input  1  jump-register
jr_target  input  ADDR_W  register-sourced target
call  input  1  push PC+INC onto RAS (link)
ret  input  1  pop RAS into PC
exc  input  1  exception/interrupt request
pc  output  ADDR_W  current PC (IM address), registered
pc_plus_inc  output  ADDR_W  pc+INC, combinational from pc
ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries
ras_full  output  1  ras_count==RAS_DEPTH
ret_underflow  output  1  registered 1-cycle pulse: ret with empty RAS

Behaviour:
- Reset (sync, highest priority): pc=RESET_PC; ras_count=0; RAS pointer=0; ret_underflow=0. Reset mid-call/ret discards the op.
- Next-PC priority, evaluated each rising edge:
  exc > stall > ret > jr > jump > branch-taken > sequential.
- exc: pc<=EXC_VECTOR. RAS unchanged. call/ret ignored, even while stall is high.
- stall (no exc): pc and RAS hold; ret_underflow<=0.
- ret, ras_count>0: pc<=RAS top; count-1.
- ret, ras_count==0: pc<=pc+INC; ret_underflow<=1 for one cycle; count stays 0.
- jr: pc<=jr_target.
- jump: pc<=jump_target.
- Branch taken: pc<=pc+INC+branch_offset.
- Otherwise: pc<=pc+INC.
- All arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- call (not stalled, no exc): pushes pc+INC. The push is independent of the redirect source, so call+jump = jump-and-link and call alone = link-and-fall-through.
- call while full: circular overwrite of oldest entry; count stays RAS_DEPTH; no error flag.
- call+ret same cycle: pc<=old top (or the underflow path if empty); top entry replaced with pc+INC; count unchanged (swap). When empty: push only, count=1, underflow pulse still asserted.
- Latency: one cycle from control inputs to pc. pc_plus_inc has zero latency from pc.
- ras_full, ras_count and ret_underflow are derived from registered state; no combinational path from inputs.

Decomposition:
- Package pc_pkg:
  - next_pc_sel_t enum {SEL_SEQ, SEL_BRANCH, SEL_JUMP, SEL_JR, SEL_RET, SEL_EXC}.
  - Default-parameter constants.
- Sub-module return_addr_stack:
  - Params DEPTH, W.
  - Ports clk, reset, push, pop, push_data, top, count, full, empty.
  - Circular pointer; pop-on-empty ignored.
- pc_unit holds the priority mux, the PC register and the underflow flag.

Test Plan:
- Reset then 3 free-running cycles (INC=1) -> pc 0,1,2,3; ras_count=0; ret_underflow=0.
- pc=10, branch=1, zero=1, offset=-3 (all ones -3) -> pc=8; same with zero=0 -> pc=11.
- pc=5: call+jump target 40 -> pc=40, ras_count=1; then ret -> pc=6, ras_count=0; then ret again -> pc=7, ret_underflow=1 for exactly one cycle.
- RAS_DEPTH=4: 5 calls from pc=0,1,2,3,4 each with jump -> ras_full=1, count=4; 4 rets return 5,4,3,2; 5th ret underflows.
- stall=1 with jump=1 for 2 cycles -> pc holds; exc asserted during stall -> pc=0x100 next cycle, ras_count unchanged.
- Wrap: pc=32'hFFFF_FFFF, sequential -> pc=0. Reset asserted same cycle as call with ras_count=2 -> pc=RESET_PC, ras_count=0.
